// File: rtl/add_comp_sched_pkg.sv
// Shared types and widths for the two-requester adder-comparator scheduler.
package add_comp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int OP_W  = 8;
  localparam int SUM_W = 9;
  localparam int NREQ  = 2;

  function automatic logic onehot3(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker: on contention the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // grant decode from request pattern and previous winner
  always_comb begin
    gnt    = 2'b00;
    gnt_id = 1'b0;
    case (req)
      2'b01: begin
        gnt    = 2'b01;
        gnt_id = 1'b0;
      end
      2'b10: begin
        gnt    = 2'b10;
        gnt_id = 1'b1;
      end
      2'b11: begin
        if (last) begin
          gnt    = 2'b01;
          gnt_id = 1'b0;
        end else begin
          gnt    = 2'b10;
          gnt_id = 1'b1;
        end
      end
      default: begin
        gnt    = 2'b00;
        gnt_id = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/add_comp_sched.sv
// Round-robin scheduler sharing one combinational adder-comparator between two clients,
// with result consistency checking and completion statistics.
module add_comp_sched
  import add_comp_sched_pkg::*;
#(
  parameter int PV    = 50,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*OP_W-1:0]    req_n1,
  input  logic [2*OP_W-1:0]    req_n2,
  output logic                 dp_en,
  output logic [OP_W-1:0]      dp_n1,
  output logic [OP_W-1:0]      dp_n2,
  input  logic [SUM_W-1:0]     dp_sum,
  input  logic                 dp_more,
  input  logic                 dp_less,
  input  logic                 dp_match,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [SUM_W-1:0]     rsp_sum,
  output logic                 rsp_more,
  output logic                 rsp_less,
  output logic                 rsp_match,
  output logic                 rsp_err,
  output logic                 err_sticky,
  output logic [CNT_W-1:0]     done_cnt,
  output logic [CNT_W-1:0]     match_cnt
);

  localparam logic [SUM_W-1:0] PV_S    = SUM_W'(PV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic [OP_W-1:0]     n1_q, n1_d, n2_q, n2_d;
  logic                rsp_id_q, rsp_id_d;
  logic [SUM_W-1:0]    rsp_sum_q, rsp_sum_d;
  logic [2:0]          rsp_flags_q, rsp_flags_d;
  logic                rsp_err_q, rsp_err_d;
  logic                err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d, match_cnt_q, match_cnt_d;

  logic [1:0]          gnt_s;
  logic                gnt_id_s;
  logic [SUM_W-1:0]    exp_sum_s;
  logic [2:0]          dp_flags_s, exp_flags_s;
  logic                chk_err_s;

  rr_arb2 u_arb (
    .req    (req_valid),
    .last   (last_q),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  // flags are ordered {more, less, match}
  assign exp_sum_s   = {1'b0, n1_q} + {1'b0, n2_q};
  assign dp_flags_s  = {dp_more, dp_less, dp_match};
  assign exp_flags_s = (dp_sum > PV_S) ? 3'b100 : ((dp_sum < PV_S) ? 3'b010 : 3'b001);
  assign chk_err_s   = (dp_sum != exp_sum_s) || !onehot3(dp_flags_s) ||
                       (dp_flags_s != exp_flags_s);

  // next-state and datapath latch logic
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    n1_d         = n1_q;
    n2_d         = n2_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    err_sticky_d = err_sticky_q;
    done_cnt_d   = done_cnt_q;
    match_cnt_d  = match_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          state_d = EXEC;
          last_d  = gnt_id_s;
          id_d    = gnt_id_s;
          n1_d    = gnt_id_s ? req_n1[2*OP_W-1:OP_W] : req_n1[OP_W-1:0];
          n2_d    = gnt_id_s ? req_n2[2*OP_W-1:OP_W] : req_n2[OP_W-1:0];
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_id_d     = id_q;
        rsp_sum_d    = dp_sum;
        rsp_flags_d  = dp_flags_s;
        rsp_err_d    = chk_err_s;
        err_sticky_d = err_sticky_q | chk_err_s;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d    = IDLE;
          done_cnt_d = done_cnt_q + CNT_ONE;
          if (rsp_flags_q[0]) begin
            match_cnt_d = match_cnt_q + CNT_ONE;
          end else begin
            match_cnt_d = match_cnt_q;
          end
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= 1'b1;
      id_q         <= 1'b0;
      n1_q         <= '0;
      n2_q         <= '0;
      rsp_id_q     <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_flags_q  <= 3'b000;
      rsp_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
      done_cnt_q   <= '0;
      match_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      id_q         <= id_d;
      n1_q         <= n1_d;
      n2_q         <= n2_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      err_sticky_q <= err_sticky_d;
      done_cnt_q   <= done_cnt_d;
      match_cnt_q  <= match_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE) ? gnt_s : 2'b00;
  assign dp_en      = (state_q == EXEC);
  assign dp_n1      = n1_q;
  assign dp_n2      = n2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_more   = rsp_flags_q[2];
  assign rsp_less   = rsp_flags_q[1];
  assign rsp_match  = rsp_flags_q[0];
  assign rsp_err    = rsp_err_q;
  assign err_sticky = err_sticky_q;
  assign done_cnt   = done_cnt_q;
  assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_add_comp_sched.sv
// Self-checking bench for add_comp_sched: directed scenarios plus randomized traffic
// against a transaction-level reference model and a fault-injectable datapath model.
module tb_add_comp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [15:0] req_n1, req_n2;
  logic        dp_en;
  logic [7:0]  dp_n1, dp_n2;
  logic [8:0]  dp_sum;
  logic        dp_more, dp_less, dp_match;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [8:0]  rsp_sum;
  logic        rsp_more, rsp_less, rsp_match, rsp_err, err_sticky;
  logic [15:0] done_cnt, match_cnt;
  logic        fault;

  int nvec = 0;
  int nerr = 0;
  int m_last, m_done, m_match;
  bit m_sticky;

  always #5 clk = ~clk;

  add_comp_sched #(.PV(50), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_n1(req_n1), .req_n2(req_n2), .dp_en(dp_en), .dp_n1(dp_n1), .dp_n2(dp_n2),
    .dp_sum(dp_sum), .dp_more(dp_more), .dp_less(dp_less), .dp_match(dp_match),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_more(rsp_more), .rsp_less(rsp_less), .rsp_match(rsp_match), .rsp_err(rsp_err),
    .err_sticky(err_sticky), .done_cnt(done_cnt), .match_cnt(match_cnt)
  );

  // behavioural adder-comparator; fault mode reports both "more" and "match"
  always_comb begin
    dp_sum = 9'(int'(dp_n1) + int'(dp_n2));
    if (fault) begin
      {dp_more, dp_less, dp_match} = 3'b101;
    end else begin
      dp_more  = (int'(dp_sum) > 50);
      dp_less  = (int'(dp_sum) < 50);
      dp_match = (int'(dp_sum) == 50);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_done   = 0;
    m_match  = 0;
    m_sticky = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    fault     = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_n1[i*8 +: 8] = 8'(a);
    req_n2[i*8 +: 8] = 8'(b);
    req_valid[i]     = 1'b1;
  endtask

  // Drive one transaction from grant to response handshake; expectations come from the model.
  task automatic serve_one(input int hold);
    int gid, a, b, s;
    bit em, el, eh, eerr;
    logic [1:0] eg;
    #1;
    if (req_valid == 2'b11) gid = 1 - m_last;
    else if (req_valid[0]) gid = 0;
    else gid = 1;
    eg = (gid == 0) ? 2'b01 : 2'b10;
    nvec++;
    if (req_ready !== eg) begin
      nerr++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, eg);
    end
    a = int'(req_n1[gid*8 +: 8]);
    b = int'(req_n2[gid*8 +: 8]);
    s = a + b;
    tick();
    m_last = gid;
    req_valid[gid] = 1'b0;
    #1;
    nvec++;
    if ({dp_en, dp_n1, dp_n2, req_ready, rsp_valid} !== {1'b1, 8'(a), 8'(b), 2'b00, 1'b0}) begin
      nerr++;
      $display("FAIL exec: en=%b n1=%0d n2=%0d rdy=%b rv=%b expected 1 %0d %0d 00 0",
               dp_en, dp_n1, dp_n2, req_ready, rsp_valid, a, b);
    end
    tick();
    if (fault) begin
      eh = 1'b1; el = 1'b0; em = 1'b1; eerr = 1'b1;
    end else begin
      eh = (s > 50); el = (s < 50); em = (s == 50); eerr = 1'b0;
    end
    m_sticky = m_sticky | eerr;
    nvec++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_more, rsp_less, rsp_match, rsp_err, err_sticky, dp_en}
        !== {1'b1, 1'(gid), 9'(s), eh, el, em, eerr, m_sticky, 1'b0}) begin
      nerr++;
      $display("FAIL resp: v=%b id=%b sum=%0d mlm=%b%b%b err=%b st=%b en=%b expected 1 %0d %0d %b%b%b %b %b 0",
               rsp_valid, rsp_id, rsp_sum, rsp_more, rsp_less, rsp_match, rsp_err, err_sticky,
               dp_en, gid, s, eh, el, em, eerr, m_sticky);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      nvec++;
      if ({rsp_valid, rsp_id, rsp_sum, rsp_more, rsp_less, rsp_match, rsp_err, req_ready}
          !== {1'b1, 1'(gid), 9'(s), eh, el, em, eerr, 2'b00}) begin
        nerr++;
        $display("FAIL hold: cycle %0d v=%b id=%b sum=%0d rdy=%b expected 1 %0d %0d 00",
                 h, rsp_valid, rsp_id, rsp_sum, req_ready, gid, s);
      end
    end
    rsp_ready = 1'b1;
    #1;
    nvec++;
    if (req_ready !== 2'b00) begin
      nerr++;
      $display("FAIL rsp_ready_path: req_ready=%b expected 00", req_ready);
    end
    tick();
    rsp_ready = 1'b0;
    m_done++;
    if (em) m_match++;
    nvec++;
    if ({rsp_valid, done_cnt, match_cnt} !== {1'b0, 16'(m_done), 16'(m_match)}) begin
      nerr++;
      $display("FAIL counters: v=%b done=%0d match=%0d expected 0 %0d %0d",
               rsp_valid, done_cnt, match_cnt, m_done, m_match);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; fault = 1'b0;
    req_n1 = 16'h0000; req_n2 = 16'h0000;
    #12;
    nvec++;
    if ({req_ready, dp_en, dp_n1, dp_n2, rsp_valid, rsp_id, rsp_sum, rsp_more, rsp_less,
         rsp_match, rsp_err, err_sticky, done_cnt, match_cnt} !== 64'd0) begin
      nerr++;
      $display("FAIL reset: outputs not all zero (sum=%0d done=%0d)", rsp_sum, done_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_single_match();
    do_reset();
    set_req(0, 20, 30);
    serve_one(0);
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(0, 10, 5);
    set_req(1, 200, 100);
    serve_one(0);
    serve_one(0);
  endtask

  task automatic test_overflow();
    set_req(1, 255, 255);
    serve_one(0);
  endtask

  task automatic test_backpressure();
    set_req(0, 7, 9);
    set_req(1, 40, 10);
    serve_one(5);
    serve_one(0);
  endtask

  task automatic test_fault();
    fault = 1'b1;
    set_req(0, 25, 25);
    serve_one(0);
    fault = 1'b0;
    set_req(1, 10, 20);
    serve_one(1);
  endtask

  task automatic test_reset_mid();
    set_req(0, 1, 2);
    #1;
    tick();
    req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({req_ready, dp_en, dp_n1, dp_n2, rsp_valid, rsp_id, rsp_sum, rsp_more, rsp_less,
         rsp_match, rsp_err, err_sticky, done_cnt, match_cnt} !== 64'd0) begin
      nerr++;
      $display("FAIL reset_mid: outputs not reset (en=%b st=%b done=%0d)", dp_en, err_sticky, done_cnt);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      nvec++;
      if ({rsp_valid, dp_en} !== 2'b00) begin
        nerr++;
        $display("FAIL reset_mid_quiet: v=%b en=%b expected 00", rsp_valid, dp_en);
      end
    end
    set_req(0, $urandom_range(0, 255), $urandom_range(0, 255));
    set_req(1, $urandom_range(0, 255), $urandom_range(0, 255));
    serve_one(0);
    serve_one(0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      if (req_valid == 2'b00) begin
        set_req($urandom_range(0, 1), $urandom_range(0, 60), $urandom_range(0, 60));
      end
      fault = ($urandom_range(0, 7) == 0);
      serve_one($urandom_range(0, 2));
      fault = 1'b0;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_match();
    test_simultaneous();
    test_overflow();
    test_backpressure();
    test_fault();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
